// File: rtl/binary_mul_5_1_bi.sv
// Signed 5x5 radix-4 Booth multiplier with one registered output stage.
// Optional p_valid output port enabled by defining BINARY_MUL_VALID_OUT_EN.
module binary_mul_5_1_bi #(
    parameter int A_W = 5,
    parameter int B_W = 5,
    parameter int P_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic [P_W-1:0] P
`ifdef BINARY_MUL_VALID_OUT_EN
    ,
    output logic           p_valid
`endif
);

    localparam int F_W   = A_W + B_W;
    localparam int B_EXT = B_W + (B_W % 2);
    localparam int NDIG  = B_EXT / 2;

    logic [F_W-1:0]   prod_full;
    logic [P_W-1:0]   P_d;
    logic [P_W-1:0]   P_q;
    logic             unused_hi;

    // Booth digits come from overlapping 3-bit windows of sign-extended B
    // with an implicit zero below the LSB; partial products wrap mod 2^F_W.
    always_comb begin
        logic [B_EXT-1:0] b_sx;
        logic [B_EXT:0]   b_win;
        logic [F_W-1:0]   a_ext;
        logic [F_W-1:0]   pp;
        logic [2:0]       trip;
        b_sx          = {B_EXT{B[B_W-1]}};
        b_sx[B_W-1:0] = B;
        b_win         = {b_sx, 1'b0};
        a_ext         = {{(F_W-A_W){A[A_W-1]}}, A};
        prod_full     = '0;
        pp            = '0;
        trip          = '0;
        for (int d = 0; d < NDIG; d++) begin
            trip = b_win[2*d +: 3];
            unique case (trip)
                3'b001,
                3'b010:  pp = a_ext;
                3'b011:  pp = a_ext << 1;
                3'b100:  pp = -(a_ext << 1);
                3'b101,
                3'b110:  pp = -a_ext;
                default: pp = '0;
            endcase
            prod_full = prod_full + (pp << (2 * d));
        end
    end

    // Only the low P_W bits leave the block; the top bit of the exact
    // product is intentionally dropped (wraps modulo 2^P_W).
    assign unused_hi = ^prod_full[F_W-1:P_W];

    // Next-state for the product register: load on en, otherwise hold.
    always_comb begin
        P_d = P_q;
        if (en) begin
            P_d = prod_full[P_W-1:0];
        end
    end

    // Product register; synchronous reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            P_q <= '0;
        end else begin
            P_q <= P_d;
        end
    end

    assign P = P_q;

`ifdef BINARY_MUL_VALID_OUT_EN
    logic p_valid_q;

    // Valid flag marks P as freshly loaded, aligned with the P register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= en;
        end
    end

    assign p_valid = p_valid_q;
`endif

endmodule

// File: tb/tb_binary_mul_5_1_bi.sv
// Self-checking bench for binary_mul_5_1_bi.
// Define BINARY_MUL_VALID_OUT_EN to also check p_valid.
module tb_binary_mul_5_1_bi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] A;
    logic [4:0] B;
    logic [8:0] P;
`ifdef BINARY_MUL_VALID_OUT_EN
    logic       p_valid;
`endif

    binary_mul_5_1_bi dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .A   (A),
        .B   (B),
        .P   (P)
`ifdef BINARY_MUL_VALID_OUT_EN
        ,
        .p_valid (p_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_bad;
    logic [8:0] sb_p[$];
    logic       sb_v[$];
    logic [8:0] mdl_p;
    logic       mdl_v;

    function automatic logic [8:0] ref_mul(int a, int b);
        int p;
        p = a * b;
        return p[8:0];
    endfunction

    // Drive one cycle of stimulus on the negedge and queue the expectation
    // for the following posedge.
    task automatic drive(input logic r, input logic e, input int a, input int b);
        @(negedge clk);
        rst = r;
        en  = e;
        A   = 5'(a);
        B   = 5'(b);
        if (r) begin
            mdl_p = '0;
            mdl_v = 1'b0;
        end else begin
            if (e) mdl_p = ref_mul(a, b);
            mdl_v = e;
        end
        sb_p.push_back(mdl_p);
        sb_v.push_back(mdl_v);
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        logic       ev;
        drive(1'b1, 1'b1, 7, 3);
        @(posedge clk); #1;
        exp = sb_p.pop_front();
        ev  = sb_v.pop_front();
        n_cmp++;
        if (P !== exp) begin
            n_bad++;
            $display("FAIL reset P got %0h want %0h", P, exp);
        end
        drive(1'b0, 1'b1, 7, 3);
        @(posedge clk); #1;
        exp = sb_p.pop_front();
        ev  = sb_v.pop_front();
        n_cmp++;
        if (P !== exp) begin
            n_bad++;
            $display("FAIL after_reset P got %0h want %0h", P, exp);
        end
        n_cmp++;
        if (P !== 9'd21) begin
            n_bad++;
            $display("FAIL after_reset_21 P got %0h want %0h", P, 9'd21);
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] exp;
        logic       ev;
        for (int a = -16; a < 16; a++) begin
            for (int b = -16; b < 16; b++) begin
                drive(1'b0, 1'b1, a, b);
                @(posedge clk); #1;
                exp = sb_p.pop_front();
                ev  = sb_v.pop_front();
                n_cmp++;
                if (P !== exp) begin
                    n_bad++;
                    $display("FAIL exhaustive A=%0d B=%0d got %0h want %0h",
                             a, b, P, exp);
                end
            end
        end
    endtask

    task automatic test_corners();
        int         ta[4];
        int         tb[4];
        logic [8:0] tp[4];
        logic [8:0] exp;
        logic       ev;
        ta = '{-16, -16, 15, 0};
        tb = '{-16, 15, 15, -16};
        tp = '{9'h100, 9'h110, 9'h0E1, 9'h000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, ta[i], tb[i]);
            @(posedge clk); #1;
            exp = sb_p.pop_front();
            ev  = sb_v.pop_front();
            n_cmp++;
            if (P !== exp || P !== tp[i]) begin
                n_bad++;
                $display("FAIL corner A=%0d B=%0d got %0h want %0h",
                         ta[i], tb[i], P, tp[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [8:0] exp;
        logic       ev;
        drive(1'b0, 1'b1, 5, -3);
        @(posedge clk); #1;
        exp = sb_p.pop_front();
        ev  = sb_v.pop_front();
        n_cmp++;
        if (P !== exp || P !== 9'h1F1) begin
            n_bad++;
            $display("FAIL hold_load got %0h want %0h", P, 9'h1F1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 9, 9);
            @(posedge clk); #1;
            exp = sb_p.pop_front();
            ev  = sb_v.pop_front();
            n_cmp++;
            if (P !== exp || P !== 9'h1F1) begin
                n_bad++;
                $display("FAIL hold_%0d got %0h want %0h", i, P, 9'h1F1);
            end
        end
        drive(1'b0, 1'b1, 9, 9);
        @(posedge clk); #1;
        exp = sb_p.pop_front();
        ev  = sb_v.pop_front();
        n_cmp++;
        if (P !== exp || P !== 9'd81) begin
            n_bad++;
            $display("FAIL hold_release got %0h want %0h", P, 9'd81);
        end
    endtask

    task automatic test_midstream_reset();
        int         ta[5];
        int         tb[5];
        logic       tr[5];
        logic [8:0] exp;
        logic       ev;
        ta = '{3, -8, 5, 6, -11};
        tb = '{4, 7, 5, -7, -13};
        tr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(tr[i], 1'b1, ta[i], tb[i]);
            @(posedge clk); #1;
            exp = sb_p.pop_front();
            ev  = sb_v.pop_front();
            n_cmp++;
            if (P !== exp) begin
                n_bad++;
                $display("FAIL midrst_%0d got %0h want %0h", i, P, exp);
            end
        end
    endtask

`ifdef BINARY_MUL_VALID_OUT_EN
    task automatic test_valid();
        logic       tr[8];
        logic       te[8];
        logic [8:0] exp;
        logic       ev;
        tr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        te = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(tr[i], te[i], i - 3, 2 * i - 7);
            @(posedge clk); #1;
            exp = sb_p.pop_front();
            ev  = sb_v.pop_front();
            n_cmp++;
            if (p_valid !== ev || P !== exp) begin
                n_bad++;
                $display("FAIL valid_%0d got v=%0b P=%0h want v=%0b P=%0h",
                         i, p_valid, P, ev, exp);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mdl_p = '0;
        mdl_v = 1'b0;
        rst   = 1'b1;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_exhaustive();
        test_corners();
        test_hold();
        test_midstream_reset();
`ifdef BINARY_MUL_VALID_OUT_EN
        test_valid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
